// File: rtl/bcd_report_pkg.sv
// Shared state encodings, character constants and EOL modes for the BCD field reporter.
package bcd_report_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LOAD     = 3'd1;
    localparam logic [2:0] ST_PREFIX   = 3'd2;
    localparam logic [2:0] ST_DIGIT_HI = 3'd3;
    localparam logic [2:0] ST_DIGIT_LO = 3'd4;
    localparam logic [2:0] ST_SEP      = 3'd5;
    localparam logic [2:0] ST_EOL      = 3'd6;
    localparam logic [2:0] ST_DONE     = 3'd7;

    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_BAD   = 8'h3F;
    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_ZERO  = 8'h30;

    localparam int EOL_LF_CR = 0;
    localparam int EOL_CR_LF = 1;
    localparam int EOL_NONE  = 2;

endpackage

// File: rtl/bcd_nibble_to_ascii.sv
// One BCD nibble to ASCII: digits map to '0'..'9', A..F become '?', and a
// zero may be blanked to a space when the caller asks for it.
module bcd_nibble_to_ascii
    import bcd_report_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank_zero,
    output logic [7:0] ascii
);

    // NOTE: assign a default first so every path drives ascii and no latch is inferred.
    always_comb begin
        ascii = CHAR_ZERO + {4'h0, nibble};
        if (nibble > 4'd9) begin
            ascii = CHAR_BAD;
        end else if (blank_zero && (nibble == 4'd0)) begin
            ascii = CHAR_SPACE;
        end
    end

endmodule

// File: rtl/bcd_field_uart_reporter.sv
// Formats NUM_FIELDS packed BCD fields into "<prefix>tt:tt..<eol>" and streams it over valid/ready.
// Define BCD_REPORTER_ZERO_BLANK_EN to send a leading zero of field 0 as a space.
module bcd_field_uart_reporter
    import bcd_report_pkg::*;
#(
    parameter int           NUM_FIELDS = 3,
    parameter int           PREFIX_LEN = 8,
    parameter logic [127:0] PREFIX     = "Time is ",
    parameter logic [7:0]   SEP_CHAR   = 8'h3A,
    parameter int           EOL_MODE   = 0,
    parameter int           TRIG_ANY   = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [8*NUM_FIELDS-1:0] fields,
    input  logic                    req,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic                    busy,
    output logic [7:0]              drop_cnt
);

    localparam int             FW          = 8 * NUM_FIELDS;
    localparam int             PL          = (PREFIX_LEN == 0) ? 1 : PREFIX_LEN;
    localparam logic [3:0]     PREFIX_LAST = 4'(PL - 1);
    localparam logic [2:0]     FIELD_LAST  = 3'(NUM_FIELDS - 1);
    localparam logic [7:0]     EOL_FIRST   = (EOL_MODE == EOL_CR_LF) ? CHAR_CR : CHAR_LF;
    localparam logic [7:0]     EOL_SECOND  = (EOL_MODE == EOL_CR_LF) ? CHAR_LF : CHAR_CR;
    localparam logic [FW-1:0]  TRIG_MASK   = (TRIG_ANY != 0) ? {FW{1'b1}} : FW'(8'hFF);

    logic [2:0]    state;
    logic [FW-1:0] prev;
    logic [FW-1:0] snap;
    logic          pending;
    logic [3:0]    byte_idx;
    logic [2:0]    field_idx;
    logic          trigger;
    logic          accept;
    logic [7:0]    cur_field;
    logic [3:0]    nibble;
    logic          blank_zero;
    logic [7:0]    digit_ascii;

    function automatic logic [7:0] prefix_at(input logic [3:0] idx);
        prefix_at = 8'h00;
        for (int k = 0; k < PREFIX_LEN; k++) begin
            if (idx == 4'(k)) prefix_at = PREFIX[8*(PREFIX_LEN-1-k) +: 8];
        end
    endfunction

    assign trigger  = req || (((fields ^ prev) & TRIG_MASK) != '0);
    assign accept   = tx_valid && tx_ready;
    assign tx_valid = state inside {ST_PREFIX, ST_DIGIT_HI, ST_DIGIT_LO, ST_SEP, ST_EOL};
    assign busy     = (state != ST_IDLE) && (state != ST_DONE);

    always_comb begin
        cur_field = 8'h00;
        for (int k = 0; k < NUM_FIELDS; k++) begin
            if (field_idx == 3'(k)) cur_field = snap[8*(NUM_FIELDS-1-k) +: 8];
        end
    end

    assign nibble = (state == ST_DIGIT_HI) ? cur_field[7:4] : cur_field[3:0];

`ifdef BCD_REPORTER_ZERO_BLANK_EN
    assign blank_zero = (state == ST_DIGIT_HI) && (field_idx == 3'd0);
`else
    assign blank_zero = 1'b0;
`endif

    bcd_nibble_to_ascii u_digit (
        .nibble     (nibble),
        .blank_zero (blank_zero),
        .ascii      (digit_ascii)
    );

    always_comb begin
        tx_data = 8'h00;
        case (state)
            ST_PREFIX:               tx_data = prefix_at(byte_idx);
            ST_DIGIT_HI, ST_DIGIT_LO: tx_data = digit_ascii;
            ST_SEP:                  tx_data = SEP_CHAR;
            ST_EOL:                  tx_data = byte_idx[0] ? EOL_SECOND : EOL_FIRST;
            default:                 tx_data = 8'h00;
        endcase
    end

    // prev resets to all-ones so the first cycle out of reset always sees a change.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            prev      <= '1;
            snap      <= '0;
            pending   <= 1'b0;
            drop_cnt  <= 8'h00;
            byte_idx  <= 4'd0;
            field_idx <= 3'd0;
        end else begin
            prev <= fields;

            // While a line is in flight, one event is queued and further ones are counted.
            if ((state != ST_IDLE) && trigger) begin
                if (!pending) begin
                    pending <= 1'b1;
                end else if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (trigger || pending) begin
                        pending <= 1'b0;
                        state   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    snap      <= fields;
                    byte_idx  <= 4'd0;
                    field_idx <= 3'd0;
                    state     <= (PREFIX_LEN == 0) ? ST_DIGIT_HI : ST_PREFIX;
                end
                ST_PREFIX: begin
                    if (accept) begin
                        if (byte_idx == PREFIX_LAST) begin
                            byte_idx <= 4'd0;
                            state    <= ST_DIGIT_HI;
                        end else begin
                            byte_idx <= byte_idx + 4'd1;
                        end
                    end
                end
                ST_DIGIT_HI: begin
                    if (accept) state <= ST_DIGIT_LO;
                end
                ST_DIGIT_LO: begin
                    if (accept) begin
                        if (field_idx == FIELD_LAST) begin
                            state <= (EOL_MODE == EOL_NONE) ? ST_DONE : ST_EOL;
                        end else begin
                            state <= ST_SEP;
                        end
                    end
                end
                ST_SEP: begin
                    if (accept) begin
                        field_idx <= field_idx + 3'd1;
                        state     <= ST_DIGIT_HI;
                    end
                end
                ST_EOL: begin
                    if (accept) begin
                        if (byte_idx[0]) begin
                            state <= ST_DONE;
                        end else begin
                            byte_idx <= byte_idx + 4'd1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_field_uart_reporter.sv
// Bench for bcd_field_uart_reporter: a default 3-field DUT and a 2-field/no-prefix/no-EOL DUT,
// checked byte-by-byte against line models built from the field values.
module tb_bcd_field_uart_reporter;

    logic        clk;
    logic        rst_n;
    logic [23:0] fields;
    logic        req;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic [7:0]  drop_cnt;

    logic [15:0] fields_s;
    logic [7:0]  tx_data_s;
    logic        tx_valid_s;
    logic        tx_ready_s;
    logic        busy_s;
    logic [7:0]  drop_cnt_s;
    logic        req_s;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [7:0] exp_main[$];
    logic [7:0] exp_small[$];
    logic [7:0] cap_main[$];
    logic [7:0] cap_small[$];

    bcd_field_uart_reporter u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .fields   (fields),
        .req      (req),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    bcd_field_uart_reporter #(
        .NUM_FIELDS (2),
        .PREFIX_LEN (0),
        .PREFIX     (128'h0),
        .EOL_MODE   (2),
        .TRIG_ANY   (1)
    ) u_small (
        .clk      (clk),
        .rst_n    (rst_n),
        .fields   (fields_s),
        .req      (req_s),
        .tx_data  (tx_data_s),
        .tx_valid (tx_valid_s),
        .tx_ready (tx_ready_s),
        .busy     (busy_s),
        .drop_cnt (drop_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // Character the line must carry for one BCD digit.
    function automatic logic [7:0] digit_ch(input logic [3:0] n, input bit leading);
        if (n > 4'd9) return 8'h3F;
`ifdef BCD_REPORTER_ZERO_BLANK_EN
        if (leading && n == 4'd0) return 8'h20;
`endif
        return 8'h30 + {4'h0, n};
    endfunction

    // Whole-line model: prefix, digit pairs joined by ':', then the chosen EOL.
    function automatic void push_line(input bit to_small, input logic [63:0] f, input int nf,
                                      input string pre, input int eol);
        logic [7:0] line[$];
        logic [7:0] b;
        for (int i = 0; i < pre.len(); i++) line.push_back(pre[i]);
        for (int k = 0; k < nf; k++) begin
            b = f[8*(nf-1-k) +: 8];
            line.push_back(digit_ch(b[7:4], k == 0));
            line.push_back(digit_ch(b[3:0], 1'b0));
            if (k < nf - 1) line.push_back(8'h3A);
        end
        if (eol == 0) begin line.push_back(8'h0A); line.push_back(8'h0D); end
        if (eol == 1) begin line.push_back(8'h0D); line.push_back(8'h0A); end
        foreach (line[i]) begin
            if (to_small) exp_small.push_back(line[i]);
            else          exp_main.push_back(line[i]);
        end
    endfunction

    function automatic void expect_main(input logic [23:0] f);
        push_line(1'b0, {40'h0, f}, 3, "Time is ", 0);
    endfunction

    function automatic void expect_small(input logic [15:0] f);
        push_line(1'b1, {48'h0, f}, 2, "", 2);
    endfunction

    task automatic check_line(input string name, input logic [7:0] got[$], input string want);
        int bad = 0;
        check({name, " length"}, got.size(), want.len());
        for (int i = 0; i < want.len(); i++) begin
            if (i >= got.size()) bad++;
            else if (got[i] != want[i]) bad++;
        end
        check({name, " bytes"}, bad, 0);
    endtask

    // Single compare process: every transferred byte against the model, plus hold-stability.
    initial begin
        bit         hold_m = 1'b0;
        logic [7:0] held_m = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_m = 1'b0;
            end else begin
                if (hold_m) begin
                    check("main valid held while stalled", int'(tx_valid), 1);
                    check("main data held while stalled", int'(tx_data), int'(held_m));
                end
                if (tx_valid && tx_ready) begin
                    if (exp_main.size() == 0) check("main extra byte", 0, 1);
                    else check("main byte", int'(tx_data), int'(exp_main.pop_front()));
                    cap_main.push_back(tx_data);
                    hold_m = 1'b0;
                end else if (tx_valid) begin
                    hold_m = 1'b1;
                    held_m = tx_data;
                end else begin
                    hold_m = 1'b0;
                end
                if (tx_valid_s && tx_ready_s) begin
                    if (exp_small.size() == 0) check("small extra byte", 0, 1);
                    else check("small byte", int'(tx_data_s), int'(exp_small.pop_front()));
                    cap_small.push_back(tx_data_s);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name, input int budget, input int div);
        int  c = 0;
        bit  done = 1'b0;
        while (!done && c < budget) begin
            step();
            tx_ready = (div <= 1) || (c % div == 0);
            c++;
            if (exp_main.size() == 0 && exp_small.size() == 0 && !busy && !busy_s) done = 1'b1;
        end
        if (!done) begin
            check({name, " timeout"}, 0, 1);
            exp_main.delete();
            exp_small.delete();
        end
        tx_ready = 1'b1;
        repeat (3) step();
    endtask

    task automatic pulse_req();
        req = 1'b1;
        step();
        req = 1'b0;
    endtask

    initial begin
        string l_050000;
        string l_small_0059;
        int    n;
`ifdef BCD_REPORTER_ZERO_BLANK_EN
        l_050000     = "Time is  5:00:00\n\r";
        l_small_0059 = " 0:59";
`else
        l_050000     = "Time is 05:00:00\n\r";
        l_small_0059 = "00:59";
`endif
        rst_n      = 1'b0;
        req        = 1'b0;
        req_s      = 1'b0;
        tx_ready   = 1'b1;
        tx_ready_s = 1'b1;
        fields     = 24'h12_34_56;
        fields_s   = 16'h59_59;
        #12;
        check("reset tx_valid", int'(tx_valid), 0);
        check("reset tx_data", int'(tx_data), 0);
        check("reset busy", int'(busy), 0);
        check("reset drop_cnt", int'(drop_cnt), 0);
        check("reset small tx_valid", int'(tx_valid_s), 0);

        // Release: the all-ones prev register makes both DUTs print once.
        expect_main(fields);
        expect_small(fields_s);
        step();
        rst_n = 1'b1;
        wait_idle("first line", 200, 1);
        check_line("first line", cap_main, "Time is 12:34:56\n\r");
        check_line("small line", cap_small, "59:59");
        repeat (40) step();
        check("static fields no resend", cap_main.size(), 18);
        check("idle busy", int'(busy), 0);

        // Back-pressure: ready one cycle in seven.
        cap_main.delete();
        expect_main(fields);
        pulse_req();
        wait_idle("slow ready", 400, 7);
        check_line("slow ready line", cap_main, "Time is 12:34:56\n\r");

        // One change mid-line queues a second line; another during that line queues a third.
        cap_main.delete();
        expect_main(24'h12_34_56);
        expect_main(24'h12_34_57);
        expect_main(24'h12_34_58);
        pulse_req();
        repeat (5) step();
        fields = 24'h12_34_57;
        n = 0;
        while (cap_main.size() < 18 && n < 100) begin step(); n++; end
        repeat (8) step();
        fields = 24'h12_34_58;
        wait_idle("pending lines", 300, 1);
        check("pending line count", cap_main.size(), 54);
        check("pending drop_cnt", int'(drop_cnt), 0);

        // Three changes during one line: one queued, two dropped.
        cap_main.delete();
        expect_main(24'h12_34_58);
        expect_main(24'h12_34_30);
        pulse_req();
        repeat (4) step();
        fields = 24'h12_34_10;
        repeat (2) step();
        fields = 24'h12_34_20;
        repeat (2) step();
        fields = 24'h12_34_30;
        wait_idle("drops", 300, 1);
        check("drops line count", cap_main.size(), 36);
        check("drops drop_cnt", int'(drop_cnt), 2);

        // Digit encoding patterns, each triggered by a last-field change.
        cap_main.delete();
        fields = 24'h1A_05_09;
        expect_main(fields);
        wait_idle("bad nibble", 200, 1);
        check_line("bad nibble line", cap_main, "Time is 1?:05:09\n\r");

        cap_main.delete();
        fields = 24'h05_00_00;
        expect_main(fields);
        wait_idle("leading zero", 200, 1);
        check_line("leading zero line", cap_main, l_050000);

        cap_main.delete();
        fields = 24'h9F_E0_07;
        expect_main(fields);
        wait_idle("hex nibbles", 200, 1);
        check_line("hex nibbles line", cap_main, "Time is 9?:?0:07\n\r");

        // First field only changes: main (last-field trigger) stays quiet, small (any-field) prints.
        cap_main.delete();
        cap_small.delete();
        fields   = 24'h11_E0_07;
        fields_s = 16'h00_59;
        expect_small(fields_s);
        wait_idle("trigger select", 200, 1);
        repeat (30) step();
        check("last-field trigger ignores field 0", cap_main.size(), 0);
        check_line("any-field trigger line", cap_small, l_small_0059);

        // Reset while a byte is stalled on the bus.
        cap_main.delete();
        cap_small.delete();
        tx_ready = 1'b0;
        expect_main(fields);
        pulse_req();
        n = 0;
        while (!tx_valid && n < 10) begin step(); n++; end
        check("stall reaches valid", int'(tx_valid), 1);
        repeat (3) step();
        #3;
        rst_n = 1'b0;
        #1;
        check("async reset tx_valid", int'(tx_valid), 0);
        check("async reset busy", int'(busy), 0);
        check("async reset drop_cnt", int'(drop_cnt), 0);
        check("async reset tx_data", int'(tx_data), 0);
        exp_main.delete();
        exp_small.delete();
        cap_main.delete();
        cap_small.delete();
        step();
        step();
        tx_ready = 1'b1;
        expect_main(fields);
        expect_small(fields_s);
        rst_n = 1'b1;
        wait_idle("after reset", 200, 1);
        check_line("after reset line", cap_main, "Time is 11:?0:07\n\r");
        check_line("after reset small line", cap_small, l_small_0059);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
